// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_pkg
// Brief    : Shared constants and FSM state encoding for the round-robin
//            arbiter that fronts the 8:1 single-bit data multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package mux_rr_arbiter_pkg;

    // Requester count is tied to the 8:1 mux this arbiter drives
    localparam int NREQ = 8;
    localparam int SELW = $clog2(NREQ);

    // Arbiter states: no owner, or one owner holding the mux
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage : mux_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Scans requests starting at
//            ptr_i and wrapping modulo NREQ; returns the first requester as
//            both a binary index and a one-hot vector.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o,
    output logic [NREQ-1:0] onehot_o
);

    logic [SELW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit to ptr_i wins
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        w_cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            // SELW-bit add wraps naturally from NREQ-1 back to 0
            w_cand = ptr_i + SELW'(k);
            if (req_i[w_cand]) begin
                found_o = 1'b1;
                idx_o   = w_cand;
            end
        end
        if (found_o) begin
            onehot_o = NREQ'(1) << idx_o;
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Round-robin arbiter sharing an 8:1 single-bit mux between 8
//            requesters. Registered one-hot grant and select, tenure capped
//            at HOLD_MAX cycles, hand-off to the next requester with no idle
//            gap, and a one-cycle pulse on every new grant.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [SELW-1:0] sel_o,
    output logic            gnt_valid_o,
    output logic            switch_o
);

    // Counter needs at least one bit even when a tenure is a single cycle
    localparam int              c_CNTW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [c_CNTW-1:0] c_HOLD_LAST = c_CNTW'(HOLD_MAX - 1);

    arb_state_e        state_q,    state_d;
    logic [SELW-1:0]   ptr_q,      ptr_d;
    logic [c_CNTW-1:0] hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]   gnt_q,      gnt_d;
    logic [SELW-1:0]   sel_q,      sel_d;
    logic              switch_q,   switch_d;

    logic              w_release;
    logic [SELW-1:0]   w_scan_ptr;
    logic              w_found;
    logic [SELW-1:0]   w_idx;
    logic [NREQ-1:0]   w_onehot;

    // Owner gives up the mux when it stops requesting or its time is up
    assign w_release = (state_q == ST_GRANT) &&
                       (!req_i[sel_q] || (hold_cnt_q == c_HOLD_LAST));

    // On release the scan must already start past the outgoing owner
    assign w_scan_ptr = w_release ? (sel_q + 1'b1) : ptr_q;

    rr_pick u_pick (
        .req_i    (req_i),
        .ptr_i    (w_scan_ptr),
        .found_o  (w_found),
        .idx_o    (w_idx),
        .onehot_o (w_onehot)
    );

    // Next-state and next-output selection for the IDLE/GRANT machine
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        switch_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i && w_found) begin
                    gnt_d      = w_onehot;
                    sel_d      = w_idx;
                    hold_cnt_d = '0;
                    switch_d   = 1'b1;
                    state_d    = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (!w_release) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    ptr_d = sel_q + 1'b1;
                    // Same-edge hand-off; the outgoing owner may win again
                    if (en_i && w_found) begin
                        gnt_d      = w_onehot;
                        sel_d      = w_idx;
                        hold_cnt_d = '0;
                        switch_d   = 1'b1;
                    end else begin
                        // sel keeps the last owner so the mux input stays quiet
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears a live tenure immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            switch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            switch_q   <= switch_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign gnt_valid_o = |gnt_q;
    assign switch_o    = switch_q;

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Directed self-checking bench for mux_rr_arbiter with HOLD_MAX=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       sw;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .req_i       (req),
        .gnt_o       (gnt),
        .sel_o       (sel),
        .gnt_valid_o (gnt_valid),
        .switch_o    (sw)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Known start point: ptr=0, idle, inputs cleared
    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rst_gnt cyc%0d got %h want 00", i, gnt); end
            checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_sel cyc%0d got %0d want 0", i, sel); end
            checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid cyc%0d got %b want 0", i, gnt_valid); end
            checks++; if (sw !== 1'b0) begin errors++; $display("FAIL rst_switch cyc%0d got %b want 0", i, sw); end
        end
        rst = 1'b0;
        tick();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL first_gnt got %h want 01", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL first_sel got %0d want 0", sel); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", gnt_valid); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL first_switch got %b want 1", sw); end
    endtask

    task automatic test_regrant();
        reset_dut();
        req = 8'h20;
        tick();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL regrant_gnt got %h want 20", gnt); end
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL regrant_sel got %0d want 5", sel); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL regrant_sw0 got %b want 1", sw); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL regrant_hold cyc%0d got %h want 20", i, gnt); end
            checks++; if (sw !== 1'b0) begin errors++; $display("FAIL regrant_hold_sw cyc%0d got %b want 0", i, sw); end
        end
        tick();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL regrant_again_gnt got %h want 20", gnt); end
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL regrant_again_sel got %0d want 5", sel); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL regrant_again_sw got %b want 1", sw); end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_sel;
        logic [7:0] exp_gnt;
        logic       exp_sw;
        reset_dut();
        req = 8'hFF;
        for (int t = 0; t < 36; t++) begin
            tick();
            exp_sel = 3'((t / 4) % 8);
            exp_gnt = 8'h01 << exp_sel;
            exp_sw  = ((t % 4) == 0);
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL rot_sel t%0d got %0d want %0d", t, sel, exp_sel); end
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rot_gnt t%0d got %h want %h", t, gnt, exp_gnt); end
            checks++; if (sw !== exp_sw) begin errors++; $display("FAIL rot_sw t%0d got %b want %b", t, sw, exp_sw); end
            checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL rot_valid t%0d got %b want 1", t, gnt_valid); end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        req = 8'h04;
        tick();
        checks++; if (sel !== 3'd2) begin errors++; $display("FAIL b2b_owner got %0d want 2", sel); end
        req = 8'h44;
        tick();
        checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL b2b_no_preempt got %h want 04", gnt); end
        req = 8'h40;
        tick();
        checks++; if (gnt !== 8'h40) begin errors++; $display("FAIL b2b_gnt got %h want 40", gnt); end
        checks++; if (sel !== 3'd6) begin errors++; $display("FAIL b2b_sel got %0d want 6", sel); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL b2b_sw got %b want 1", sw); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", gnt_valid); end
    endtask

    task automatic test_enable();
        reset_dut();
        req = 8'h02;
        tick();
        checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL en_owner got %h want 02", gnt); end
        en  = 1'b0;
        req = 8'h82;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL en_tenure cyc%0d got %h want 02", i, gnt); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL en_blocked_gnt cyc%0d got %h want 00", i, gnt); end
            checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL en_blocked_valid cyc%0d got %b want 0", i, gnt_valid); end
        end
        en = 1'b1;
        tick();
        checks++; if (gnt !== 8'h80) begin errors++; $display("FAIL en_resume_gnt got %h want 80", gnt); end
        checks++; if (sel !== 3'd7) begin errors++; $display("FAIL en_resume_sel got %0d want 7", sel); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL en_resume_sw got %b want 1", sw); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        req = 8'h10;
        tick();
        checks++; if (sel !== 3'd4) begin errors++; $display("FAIL ar_owner got %0d want 4", sel); end
        tick();
        #1;
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL ar_gnt got %h want 00", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL ar_sel got %0d want 0", sel); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", gnt_valid); end
        checks++; if (sw !== 1'b0) begin errors++; $display("FAIL ar_sw got %b want 0", sw); end
        #1;
        rst = 1'b0;
        req = 8'h11;
        tick();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL ar_after_gnt got %h want 01", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL ar_after_sel got %0d want 0", sel); end
        checks++; if (sw !== 1'b1) begin errors++; $display("FAIL ar_after_sw got %b want 1", sw); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        req = 8'h00;
        test_reset();
        test_regrant();
        test_rotation();
        test_back_to_back();
        test_enable();
        test_async_reset();
        req = 8'h00;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
